// File: rtl/e1_par2seq_if.sv
// Frame-in / word-out handshake bundle for e1_par2seq.
// The unpacker connects through the slave modport and the frame producer through the master modport.
interface e1_par2seq_if #(
    parameter int SEQ_CNT        = 5,
    parameter int APP_DATA_WIDTH = 64
);
    logic                              par_valid;
    logic                              par_ready;
    logic [APP_DATA_WIDTH*SEQ_CNT-1:0] par;
    logic                              seq_valid;
    logic                              seq_ready;
    logic [APP_DATA_WIDTH-1:0]         seq;
    logic                              seq_last;
    logic                              busy;

    modport slave (
        input  par_valid, par, seq_ready,
        output par_ready, seq_valid, seq, seq_last, busy
    );

    modport master (
        output par_valid, par, seq_ready,
        input  par_ready, seq_valid, seq, seq_last, busy
    );
endinterface

// File: rtl/e1_par2seq.sv
// Parallel-to-serial unpacker: one SEQ_CNT-word frame in, one word per beat out, lowest slice first.
// Define E1_PAR2SEQ_PREFETCH_EN to add a one-frame hold register that removes the inter-frame bubble.
//
// state | meaning
// IDLE  | no frame in the shift register, waiting for a frame
// SHIFT | presenting sr low word, shifting on each beat
module e1_par2seq #(
    parameter int SEQ_CNT        = 5,
    parameter int APP_DATA_WIDTH = 64
) (
    input  logic         clk,
    input  logic         rst,
    e1_par2seq_if.slave  bus
);
    localparam int CW = (SEQ_CNT > 1) ? $clog2(SEQ_CNT) : 1;
    localparam int FW = SEQ_CNT * APP_DATA_WIDTH;
    localparam logic [CW-1:0] CNT_LAST = CW'(SEQ_CNT - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [FW-1:0]   sr_q, sr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            hold_valid;
    logic            beat;
    logic            last_beat;
    logic            accept;

`ifdef E1_PAR2SEQ_PREFETCH_EN
    logic [FW-1:0]   hold_q, hold_d;
    logic            hold_valid_q, hold_valid_d;

    assign hold_valid    = hold_valid_q;
    assign bus.par_ready = !hold_valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
        end else begin
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
        end
    end
`else
    assign hold_valid    = 1'b0;
    assign bus.par_ready = (state_q == IDLE);
`endif

    assign bus.seq_valid = (state_q == SHIFT);
    assign bus.seq       = sr_q[APP_DATA_WIDTH-1:0];
    assign bus.seq_last  = bus.seq_valid && (cnt_q == CNT_LAST);
    assign bus.busy      = (state_q == SHIFT) || hold_valid;

    assign beat      = bus.seq_valid && bus.seq_ready;
    assign last_beat = beat && (cnt_q == CNT_LAST);
    assign accept    = bus.par_valid && bus.par_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
`ifdef E1_PAR2SEQ_PREFETCH_EN
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    sr_d    = bus.par;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (beat) begin
                    sr_d  = sr_q >> APP_DATA_WIDTH;
                    cnt_d = cnt_q + CW'(1);
                    if (last_beat) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end
`ifdef E1_PAR2SEQ_PREFETCH_EN
                // A queued frame takes priority over a bypass; par_ready is low whenever hold is full.
                if (last_beat && hold_valid_q) begin
                    sr_d         = hold_q;
                    hold_valid_d = 1'b0;
                    state_d      = SHIFT;
                end else if (last_beat && accept) begin
                    sr_d    = bus.par;
                    state_d = SHIFT;
                end else if (accept) begin
                    hold_d       = bus.par;
                    hold_valid_d = 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end
endmodule
